// File: rtl/pwm_servo.sv
// PWM servo output stage: maps the signed control word to a clamped duty and generates PWM.
// Optional macro SERVO_SIGN_MAG_EN selects sign/magnitude mapping and adds the dir output.
module pwm_servo #(
    parameter int N        = 19,
    parameter int CNT_W    = 10,
    parameter int PERIOD   = 1000,
    parameter int DUTY_MAX = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [N-1:0] u,
    input  logic                run,
    output logic                pwm,
    output logic                sample_tick,
    output logic [CNT_W-1:0]    duty,
    output logic                sat
`ifdef SERVO_SIGN_MAG_EN
    ,
    output logic                dir
`endif
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DMAX   = CNT_W'(DUTY_MAX);
    localparam logic [N-1:0]     DMAX_N = N'(DUTY_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     u_q, u_d;
    logic             vld_q, vld_d;
    logic             pwm_q, pwm_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] duty_shadow;
    logic             sat_shadow;
    logic             at_last;
    logic             start;
    logic             load;
`ifdef SERVO_SIGN_MAG_EN
    logic             dir_q, dir_d;
    logic             dir_shadow;
    logic [N-1:0]     mag;
`endif

    // Duty mapping from the registered control word
    always_comb begin
        duty_shadow = '0;
        sat_shadow  = 1'b0;
`ifdef SERVO_SIGN_MAG_EN
        dir_shadow = u_q[N-1];
        // Unsigned magnitude: the most negative word becomes 2^(N-1) and clamps
        if (u_q[N-1]) begin
            mag = (~u_q) + N'(1);
        end else begin
            mag = u_q;
        end
        if (mag > DMAX_N) begin
            duty_shadow = DMAX;
            sat_shadow  = 1'b1;
        end else begin
            duty_shadow = mag[CNT_W-1:0];
            sat_shadow  = 1'b0;
        end
`else
        if (u_q[N-1]) begin
            duty_shadow = '0;
            sat_shadow  = 1'b1;
        end else if (u_q > DMAX_N) begin
            duty_shadow = DMAX;
            sat_shadow  = 1'b1;
        end else begin
            duty_shadow = u_q[CNT_W-1:0];
            sat_shadow  = 1'b0;
        end
`endif
    end

    // Next-state, counter and output logic
    always_comb begin
        at_last = (cnt_q == LAST);
        // vld_q keeps the first post-reset start from using the cleared u_q
        start   = (state_q == IDLE) && run && vld_q;
        load    = at_last || start;
        u_d     = u;
        vld_d   = 1'b1;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
                else       state_d = IDLE;
            end
            RUN: begin
                if (!run) state_d = STOP;
                else      state_d = RUN;
            end
            // STOP always finishes its period; run at the boundary decides resume vs idle
            STOP: begin
                if (at_last) state_d = run ? RUN : IDLE;
                else         state_d = STOP;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q == IDLE) || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (load) begin
            duty_d = duty_shadow;
            sat_d  = sat_shadow;
        end else begin
            duty_d = duty_q;
            sat_d  = sat_q;
        end
`ifdef SERVO_SIGN_MAG_EN
        if (load) begin
            dir_d = dir_shadow;
        end else begin
            dir_d = dir_q;
        end
`endif
        pwm_d  = (state_q != IDLE) && (cnt_q < duty_q);
        tick_d = (state_q == RUN) && at_last;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            u_q     <= '0;
            vld_q   <= 1'b0;
            pwm_q   <= 1'b0;
            tick_q  <= 1'b0;
            duty_q  <= '0;
            sat_q   <= 1'b0;
`ifdef SERVO_SIGN_MAG_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            u_q     <= u_d;
            vld_q   <= vld_d;
            pwm_q   <= pwm_d;
            tick_q  <= tick_d;
            duty_q  <= duty_d;
            sat_q   <= sat_d;
`ifdef SERVO_SIGN_MAG_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign pwm         = pwm_q;
    assign sample_tick = tick_q;
    assign duty        = duty_q;
    assign sat         = sat_q;
`ifdef SERVO_SIGN_MAG_EN
    assign dir         = dir_q;
`endif

endmodule

// File: tb/tb_pwm_servo.sv
// Directed self-checking bench for pwm_servo (PERIOD=1000, DUTY_MAX=1000).
// Expectations follow SERVO_SIGN_MAG_EN when that macro is defined.
module tb_pwm_servo;

    localparam int N     = 19;
    localparam int CNT_W = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [N-1:0] u;
    logic                run;
    logic                pwm;
    logic                sample_tick;
    logic [CNT_W-1:0]    duty;
    logic                sat;
`ifdef SERVO_SIGN_MAG_EN
    logic                dir;
    localparam int NEG3_DUTY = 3;
    localparam int NEG3_SAT  = 0;
    localparam int MIN_DUTY  = 1000;
`else
    localparam int NEG3_DUTY = 0;
    localparam int NEG3_SAT  = 1;
    localparam int MIN_DUTY  = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int win_high, win_tick, win_tick_at;
    int h_a, h_b;

    pwm_servo #(.N(N), .CNT_W(CNT_W), .PERIOD(1000), .DUTY_MAX(1000)) dut (
        .clk         (clk),
        .reset       (reset),
        .u           (u),
        .run         (run),
        .pwm         (pwm),
        .sample_tick (sample_tick),
        .duty        (duty),
        .sat         (sat)
`ifdef SERVO_SIGN_MAG_EN
        ,
        .dir         (dir)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance n cycles, counting pwm-high samples and sample_tick pulses
    task automatic run_window(input int n);
        win_high    = 0;
        win_tick    = 0;
        win_tick_at = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (pwm) win_high++;
            if (sample_tick) begin
                win_tick++;
                win_tick_at = i;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        u     = '0;
        step(2);
        check("rst_pwm", pwm, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_duty", duty, 0);
        check("rst_sat", sat, 0);
`ifdef SERVO_SIGN_MAG_EN
        check("rst_dir", dir, 0);
`endif

        reset = 1'b0;
        u     = N'(250);
        step(3);
        check("idle_pwm", pwm, 0);
        check("idle_duty_hold", duty, 0);

        run = 1'b1;
        step(1);
        check("start_duty", duty, 250);
        check("start_sat", sat, 0);
        run_window(1000);
        check("p250_high", win_high, 250);
        check("p250_ticks", win_tick, 1);
        check("p250_tick_at", win_tick_at, 1000);

        // Mid-period change of u must not affect the running period
        run_window(400);
        h_a = win_high;
        u   = N'(600);
        run_window(1);
        h_b = win_high;
        check("mid_duty_hold", duty, 250);
        run_window(599);
        check("mid_period_high", h_a + h_b + win_high, 250);
        check("next_duty_600", duty, 600);
        run_window(1000);
        check("p600_high", win_high, 600);
        check("p600_ticks", win_tick, 1);

        // Clamp high: pwm solid across the wrap
        u = N'(5000);
        run_window(1000);
        check("pre5000_high", win_high, 600);
        check("big_duty", duty, 1000);
        check("big_sat", sat, 1);
        run_window(2000);
        check("big_high_2p", win_high, 2000);
        check("big_ticks_2p", win_tick, 2);

        u = N'(-3);
        run_window(1000);
        check("pre_neg3_high", win_high, 1000);
        check("neg3_duty", duty, NEG3_DUTY);
        check("neg3_sat", sat, NEG3_SAT);
`ifdef SERVO_SIGN_MAG_EN
        check("neg3_dir", dir, 1);
`endif
        run_window(1000);
        check("neg3_high", win_high, NEG3_DUTY);

        u = {1'b1, {(N-1){1'b0}}};
        run_window(1000);
        check("min_duty", duty, MIN_DUTY);
        check("min_sat", sat, 1);

        // Run drops mid-period: finish the period, then idle
        u = N'(600);
        run_window(1000);
        check("reload600", duty, 600);
        run_window(400);
        check("drop_pre_high", win_high, 400);
        run = 1'b0;
        run_window(600);
        check("stop_high", win_high, 200);
        check("stop_ticks", win_tick, 0);
        run_window(500);
        check("idle_high", win_high, 0);
        check("idle_ticks", win_tick, 0);
        check("idle_duty_kept", duty, 600);

        // Run reasserted during STOP: period completes untick'd, then resumes
        run = 1'b1;
        step(1);
        run_window(400);
        run = 1'b0;
        run_window(300);
        check("stop2_high", win_high, 200);
        run = 1'b1;
        run_window(300);
        check("stop2_tail_high", win_high, 0);
        check("stop2_tail_ticks", win_tick, 0);
        run_window(1000);
        check("resume_high", win_high, 600);
        check("resume_ticks", win_tick, 1);
        check("resume_tick_at", win_tick_at, 1000);

        // Reset mid-period with run held high
        u = N'(500);
        run_window(1000);
        check("load500", duty, 500);
        run_window(123);
        check("pre_rst_pwm", pwm, 1);
        reset = 1'b1;
        step(1);
        check("mrst_pwm", pwm, 0);
        check("mrst_duty", duty, 0);
        check("mrst_tick", sample_tick, 0);
        check("mrst_sat", sat, 0);
        reset = 1'b0;
        step(2);
        check("restart_duty", duty, 500);
        run_window(1000);
        check("restart_high", win_high, 500);
        check("restart_ticks", win_tick, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
